// File: rtl/random_range_gen.sv
// random_range_gen: LFSR-driven generator of uniform random numbers below a requested bound.
module random_range_gen #(
  parameter int               WIDTH        = 13,
  parameter logic [WIDTH-1:0] TAPS         = 13'h100D,
  parameter int               SHIFTS       = 13,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 13'h1ACE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             req,
  input  logic [WIDTH-1:0] range,
  output logic [WIDTH-1:0] rnd,
  output logic             valid,
  output logic             busy
);
  localparam int CW = SHIFTS > 1 ? $clog2(SHIFTS) : 1;
  typedef enum logic {IDLE, WAIT} state_t;
  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_lfsr, r_rnd, r_range, r_mask, w_mask, w_cand;
  logic [CW-1:0]    r_cnt;
  logic             r_valid, w_fb, w_tick, w_hit, w_acc;
  always_comb begin
    w_fb   = ^(r_lfsr & TAPS);
    w_tick = !seed_load && r_cnt == CW'(SHIFTS - 1);
    w_cand = r_lfsr & r_mask;
    w_hit  = r_state == WAIT && w_tick && (r_range == '0 || w_cand < r_range);
    w_acc  = r_state == IDLE && !r_valid && req;
    w_next = w_acc ? WAIT : w_hit ? IDLE : r_state;
    // smear range-1 right so every bit below its MSB is set: smallest 2^k-1 >= range-1
    w_mask = range - WIDTH'(1);
    for (int i = 0; i < WIDTH; i++) w_mask = w_mask | (w_mask >> 1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_lfsr  <= DEFAULT_SEED;
      r_cnt   <= '0;
      r_rnd   <= '0;
      r_valid <= 1'b0;
      r_range <= '0;
      r_mask  <= '0;
    end else begin
      r_state <= w_next;
      r_valid <= w_hit;
      if (w_hit) r_rnd <= w_cand;
      if (w_acc) begin
        r_range <= range;
        r_mask  <= w_mask;
      end
      r_lfsr <= seed_load ? (seed == '0 ? DEFAULT_SEED : seed) :
                r_lfsr == '0 ? DEFAULT_SEED : {r_lfsr[WIDTH-2:0], w_fb};
      r_cnt  <= (seed_load || r_cnt == CW'(SHIFTS - 1)) ? '0 : r_cnt + 1'b1;
    end
  end
  assign rnd   = r_rnd;
  assign valid = r_valid;
  assign busy  = r_state == WAIT || r_valid;
endmodule

// File: tb/tb_random_range_gen.sv
// tb_random_range_gen: directed checks plus a cycle-level reference model of random_range_gen.
module tb_random_range_gen;
  logic        clk, rst, seed_load, req;
  logic [12:0] seed, rng, rnd;
  logic        valid, busy;
  logic        s_load, s_req, s_valid, s_busy;
  logic [3:0]  s_seed, s_rng, s_rnd;
  int          n_cmp = 0, n_bad = 0;
  bit          mon = 0;
  logic [12:0] m_lfsr, m_rnd, m_range, m_mask, m_cand;
  int          m_cnt;
  bit          m_wait, m_valid, m_nv;
  logic [3:0]  tbl [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                            4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

  random_range_gen u_dut (
    .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .req(req),
    .range(rng), .rnd(rnd), .valid(valid), .busy(busy)
  );

  random_range_gen #(.WIDTH(4), .TAPS(4'hC), .SHIFTS(4), .DEFAULT_SEED(4'h9)) u_small (
    .clk(clk), .rst(rst), .seed_load(s_load), .seed(s_seed), .req(s_req),
    .range(s_rng), .rnd(s_rnd), .valid(s_valid), .busy(s_busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [12:0] mask_of(input logic [12:0] r);
    if (r == 0) return 13'h1FFF;
    for (int k = 0; k <= 13; k++)
      if ((1 << k) - 1 >= int'(r) - 1) return 13'((1 << k) - 1);
    return 13'h1FFF;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr = 13'h1ACE; m_cnt = 0; m_wait = 0; m_valid = 0;
      m_rnd = 0; m_range = 0; m_mask = 0;
    end else begin
      m_nv = 0;
      m_cand = m_lfsr & m_mask;
      if (m_wait && !seed_load && m_cnt == 12) begin
        if (m_range == 0 || m_cand < m_range) begin
          m_rnd = m_cand; m_nv = 1; m_wait = 0;
        end
      end else if (!m_wait && !m_valid && req) begin
        m_wait = 1; m_range = rng; m_mask = mask_of(rng);
      end
      m_valid = m_nv;
      if (seed_load) m_lfsr = (seed == 0) ? 13'h1ACE : seed;
      else if (m_lfsr == 0) m_lfsr = 13'h1ACE;
      else m_lfsr = {m_lfsr[11:0], ^(m_lfsr & 13'h100D)};
      m_cnt = seed_load ? 0 : (m_cnt + 1) % 13;
    end
  end

  always @(posedge clk) begin
    if (mon) begin
      #2;
      check("mon_rnd", rnd, m_rnd);
      check("mon_valid", valid, m_valid);
      check("mon_busy", busy, m_wait || m_valid);
      check("mon_lfsr", u_dut.r_lfsr, m_lfsr);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!valid && n < 200) begin step(); n++; end
    check("req_valid", valid, 1);
  endtask

  task automatic do_req(input logic [12:0] r, output logic [12:0] got);
    int n = 0;
    while (busy && n < 200) begin step(); n++; end
    req = 1; rng = r;
    step();
    req = 0;
    wait_valid();
    got = rnd;
  endtask

  task automatic count_valids(input int cycles, output int nv);
    nv = 0;
    for (int i = 0; i < cycles; i++) begin step(); if (valid) nv++; end
  endtask

  initial begin
    logic [12:0] got;
    int hist [10];
    int nv, ok;
    rst = 1; seed_load = 0; seed = 0; req = 0; rng = 0;
    s_load = 0; s_seed = 0; s_req = 0; s_rng = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rnd", rnd, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_lfsr", u_dut.r_lfsr, 13'h1ACE);
    rst = 0; mon = 1;

    seed_load = 1; seed = 0; step(); seed_load = 0;
    check("seed_zero", u_dut.r_lfsr, 13'h1ACE);
    seed_load = 1; seed = 13'h0ABC; step(); seed_load = 0;
    check("seed_load", u_dut.r_lfsr, 13'h0ABC);

    s_load = 1; s_seed = 4'h1; step(); s_load = 0;
    check("p15_load", u_small.r_lfsr, 4'h1);
    for (int i = 1; i <= 15; i++) begin
      step();
      check("p15_seq", u_small.r_lfsr, tbl[i % 15]);
    end

    for (int i = 0; i < 300; i++) begin
      do_req(13'd1, got);
      check("r1_zero", got, 0);
      step();
      check("r1_pulse", valid, 0);
    end

    foreach (hist[i]) hist[i] = 0;
    for (int i = 0; i < 3500; i++) begin
      do_req(13'd10, got);
      check("r10_bound", got < 10, 1);
      if (got < 10) hist[got]++;
    end
    foreach (hist[i]) begin
      ok = (hist[i] * 20 >= 350 * 17 && hist[i] * 20 <= 350 * 23) ? 1 : 0;
      check($sformatf("r10_hist%0d", i), ok, 1);
    end

    while (busy) step();
    req = 1; rng = 0; step(); req = 0;
    check("r0_busy", busy, 1);
    req = 1; rng = 13'd5; step(); req = 0;
    count_valids(40, nv);
    check("r0_single_valid", nv, 1);

    req = 1; rng = 0; step(); req = 0;
    wait_valid();
    req = 1; rng = 13'd3; step(); req = 0;
    check("valid_cycle_req_busy", busy, 0);
    count_valids(40, nv);
    check("valid_cycle_req_ignored", nv, 0);

    req = 1; rng = 13'd10; step(); req = 0;
    repeat (3) step();
    check("abort_busy_pre", busy, 1);
    rst = 1; step(); rst = 0;
    check("abort_busy", busy, 0);
    check("abort_rnd", rnd, 0);
    check("abort_valid", valid, 0);
    check("abort_lfsr", u_dut.r_lfsr, 13'h1ACE);
    count_valids(40, nv);
    check("abort_no_stale", nv, 0);
    do_req(13'd10, got);
    check("abort_new_bound", got < 10, 1);
    step();

    mon = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/random_range_gen.md
RANDOM_RANGE_GEN -- requirements
Module: random_range_gen

Interface
REQ-001 Parameter WIDTH, default 13, is the LFSR and output width in bits (legal range 4..32).
REQ-002 Parameter TAPS, default 13'h100D, is the feedback tap mask: bit i set means LFSR bit i enters the feedback XOR.
REQ-003 Parameter SHIFTS, default 13, is the number of LFSR shifts per sample tick (legal range 1..WIDTH).
REQ-004 Parameter DEFAULT_SEED, default 13'h1ACE, is the non-zero LFSR reset and recovery value.
REQ-005 clk  input  1  system clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 seed_load  input  1  loads seed into the LFSR this cycle.
REQ-008 seed  input  WIDTH  seed value used when seed_load=1.
REQ-009 req  input  1  requests one bounded random number; accepted only while busy=0.
REQ-010 range  input  WIDTH  exclusive upper bound, sampled when req is accepted; 0 means unbounded.
REQ-011 rnd  output  WIDTH  last delivered random number, held until the next delivery.
REQ-012 valid  output  1  one-cycle pulse marking a new rnd value.
REQ-013 busy  output  1  high from the cycle after req acceptance until the cycle after valid.

Function
REQ-014 The LFSR shall shift left every cycle when not in reset and not loading, with feedback = XOR of (lfsr & TAPS) inserted at bit 0.
REQ-015 A 0..SHIFTS-1 counter shall increment every shifting cycle and wrap to 0; a sample tick occurs in the cycle the counter equals SHIFTS-1.
REQ-016 The sample value shall be the LFSR register value during the tick cycle.
REQ-017 If the LFSR ever holds all zeros, the next LFSR value shall be DEFAULT_SEED instead of the shift result.
REQ-018 seed_load=1 shall set lfsr<=seed (DEFAULT_SEED if seed==0) and counter<=0; the FSM state is unaffected.
REQ-019 FSM states: IDLE, WAIT; the state resets to IDLE.
REQ-020 IDLE: req=1 shall latch range into range_q, compute mask_q, and move to WAIT; busy=1 from the next cycle.
REQ-021 mask_q shall be the smallest 2^k-1 >= range-1, with k>=0; range 0 or 1 gives mask all-ones and all-zeros respectively.
REQ-022 WAIT, on each sample tick: cand = sample & mask_q; if range_q==0 or cand<range_q, then rnd<=cand and valid=1 next cycle, and the FSM returns to IDLE; otherwise it stays in WAIT (rejection).
REQ-023 Rejection sampling shall bound the expected wait to at most 2 ticks; no cycle cap shall be imposed.
REQ-024 req while busy=1, or in the same cycle valid is high, shall be ignored; there is no queueing.
REQ-025 seed_load while in WAIT restarts the tick counter, so the next tick is SHIFTS cycles later.
REQ-026 Output latency from req acceptance to valid shall be between 1 and SHIFTS+1 cycles for an accepted first sample.

Reset
REQ-027 rst=1 shall set lfsr=DEFAULT_SEED, counter=0, state=IDLE, rnd=0, valid=0, busy=0, range_q=0, mask_q=0.
REQ-028 rst shall take priority over seed_load and req in the same cycle.
REQ-029 rst asserted in WAIT shall abort the request, with no valid pulse.

Verification
REQ-030 WIDTH=4, TAPS=4'hC, seed_load seed=4'h1 -> the LFSR returns to 4'h1 after exactly 15 shifts and never holds 0.
REQ-031 seed_load seed=0 -> LFSR=DEFAULT_SEED the next cycle; force lfsr=0 -> next value DEFAULT_SEED.
REQ-032 Default params, range=1, 1000 requests -> every rnd=0 and each valid is a single-cycle pulse.
REQ-033 range=10, 10000 requests -> all rnd<10, each value's count within ±15% of 1000, and rnd matches a bit-exact reference model.
REQ-034 range=0 -> rnd equals the full WIDTH-bit sample at the tick; a req pulsed during busy yields no extra valid.
REQ-035 rst mid-WAIT, then req -> no stale valid, and busy, rnd, and lfsr match their reset values before the new request.
